// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//
// Circular instruction queue sitting between the fetch stage (IF) and the
// decoder. IF pushes {instruction, PC} pairs; the decoder pops one entry per
// cycle whenever it is ready. The queue raises a registered almost-full flag
// early enough to absorb IF's in-flight push, and the reorder buffer can flush
// every entry on a mispredict or exception. A low global ready freezes all
// state and outputs.
//
// Ports:
//   clk_in                      clock, rising edge
//   rst_in                      asynchronous active-low reset
//   rdy_in                      global ready; low freezes everything
//   if_instqueue_en_in          push strobe from IF
//   if_instqueue_inst_in        pushed instruction word
//   if_instqueue_pc_in          pushed PC
//   instqueue_if_full_out       almost-full back-pressure to IF
//   decoder_instqueue_rdy_in    decoder can accept an entry this cycle
//   instqueue_decoder_en_out    one-cycle strobe marking a valid output entry
//   instqueue_decoder_inst_out  popped instruction word
//   instqueue_decoder_pc_out    popped PC
//   rob_instqueue_clear_in      flush all entries
// -----------------------------------------------------------------------------
module inst_queue #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int INST_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_instqueue_en_in,
    input  logic [INST_W-1:0] if_instqueue_inst_in,
    input  logic [ADDR_W-1:0] if_instqueue_pc_in,
    output logic              instqueue_if_full_out,
    input  logic              decoder_instqueue_rdy_in,
    output logic              instqueue_decoder_en_out,
    output logic [INST_W-1:0] instqueue_decoder_inst_out,
    output logic [ADDR_W-1:0] instqueue_decoder_pc_out,
    input  logic              rob_instqueue_clear_in
);

    localparam logic [IDX_W:0] DEPTH_C   = (IDX_W+1)'(DEPTH);
    // Two entries of slack: IF registers its push, so one more may already be
    // on its way when it first sees the flag.
    localparam logic [IDX_W:0] FULL_TH_C = (IDX_W+1)'(DEPTH - 2);

    // Storage is deliberately left unreset; only the pointers define validity.
    logic [INST_W-1:0] instMem_q [DEPTH];
    logic [ADDR_W-1:0] pcMem_q   [DEPTH];

    logic [IDX_W-1:0]  head_q,    head_d;
    logic [IDX_W-1:0]  tail_q,    tail_d;
    logic [IDX_W:0]    count_q,   count_d;
    logic              en_q,      en_d;
    logic [INST_W-1:0] instOut_q, instOut_d;
    logic [ADDR_W-1:0] pcOut_q,   pcOut_d;
    logic              full_q,    full_d;
    logic              push;
    logic              pop;

    // Next-state logic. Clear beats pop and push; a pop frees a slot so a push
    // into a completely full queue is still accepted when it pairs with a pop.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        en_d      = en_q;
        instOut_d = instOut_q;
        pcOut_d   = pcOut_q;
        full_d    = full_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (rdy_in) begin
            if (rob_instqueue_clear_in) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                en_d    = 1'b0;
                full_d  = 1'b0;
            end else begin
                pop  = decoder_instqueue_rdy_in && (count_q != '0);
                push = if_instqueue_en_in && ((count_q < DEPTH_C) || pop);
                if (pop) begin
                    instOut_d = instMem_q[head_q];
                    pcOut_d   = pcMem_q[head_q];
                    en_d      = 1'b1;
                    head_d    = head_q + 1'b1;
                end else begin
                    en_d = 1'b0;
                end
                if (push) begin
                    tail_d = tail_q + 1'b1;
                end
                count_d = count_q + (IDX_W+1)'(push) - (IDX_W+1)'(pop);
                full_d  = (count_d >= FULL_TH_C);
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            en_q      <= 1'b0;
            instOut_q <= '0;
            pcOut_q   <= '0;
            full_q    <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            en_q      <= en_d;
            instOut_q <= instOut_d;
            pcOut_q   <= pcOut_d;
            full_q    <= full_d;
        end
    end

    // Entry storage; push is already qualified by rdy_in and clear.
    always_ff @(posedge clk_in) begin
        if (push) begin
            instMem_q[tail_q] <= if_instqueue_inst_in;
            pcMem_q[tail_q]   <= if_instqueue_pc_in;
        end
    end

    assign instqueue_if_full_out      = full_q;
    assign instqueue_decoder_en_out   = en_q;
    assign instqueue_decoder_inst_out = instOut_q;
    assign instqueue_decoder_pc_out   = pcOut_q;

endmodule

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue
//
// Self-checking bench for inst_queue. A queue-based reference model tracks the
// stored entries and the expected output registers; every cycle the DUT
// outputs are compared against it, followed by directed scenarios and a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_inst_queue;

    localparam int DEPTH  = 16;
    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rstN;
    logic              rdy;
    logic              ifEn;
    logic [INST_W-1:0] ifInst;
    logic [ADDR_W-1:0] ifPc;
    logic              fullOut;
    logic              decRdy;
    logic              decEn;
    logic [INST_W-1:0] decInst;
    logic [ADDR_W-1:0] decPc;
    logic              clear;

    int compared   = 0;
    int mismatched = 0;
    int dropped    = 0;

    // Reference model state
    logic [INST_W+ADDR_W-1:0] mQueue[$];
    logic                     mEn;
    logic [INST_W-1:0]        mInst;
    logic [ADDR_W-1:0]        mPc;
    logic                     mFull;

    inst_queue #(
        .DEPTH (DEPTH),
        .IDX_W (4),
        .INST_W(INST_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk_in                    (clk),
        .rst_in                    (rstN),
        .rdy_in                    (rdy),
        .if_instqueue_en_in        (ifEn),
        .if_instqueue_inst_in      (ifInst),
        .if_instqueue_pc_in        (ifPc),
        .instqueue_if_full_out     (fullOut),
        .decoder_instqueue_rdy_in  (decRdy),
        .instqueue_decoder_en_out  (decEn),
        .instqueue_decoder_inst_out(decInst),
        .instqueue_decoder_pc_out  (decPc),
        .rob_instqueue_clear_in    (clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".en"},   64'(decEn),   64'(mEn));
        checkVal({tag, ".full"}, 64'(fullOut), 64'(mFull));
        checkVal({tag, ".inst"}, 64'(decInst), 64'(mInst));
        checkVal({tag, ".pc"},   64'(decPc),   64'(mPc));
    endtask

    task automatic modelReset();
        mQueue.delete();
        mEn   = 1'b0;
        mInst = '0;
        mPc   = '0;
        mFull = 1'b0;
    endtask

    // One clock edge of the model, computed from the queue occupancy.
    task automatic modelEdge();
        bit doPop;
        bit doPush;
        int sizeBefore;
        if (!rdy) return;
        if (clear) begin
            mQueue.delete();
            mEn   = 1'b0;
            mFull = 1'b0;
            return;
        end
        sizeBefore = mQueue.size();
        doPop  = decRdy && (sizeBefore != 0);
        doPush = ifEn && ((sizeBefore < DEPTH) || doPop);
        if (ifEn && !doPush) begin
            dropped++;
            $display("[TB] protocol violation flagged: push into full queue dropped (pc=%h)", ifPc);
        end
        if (doPop) begin
            {mInst, mPc} = mQueue.pop_front();
            mEn = 1'b1;
        end else begin
            mEn = 1'b0;
        end
        if (doPush) mQueue.push_back({ifInst, ifPc});
        mFull = (mQueue.size() >= DEPTH - 2);
    endtask

    // Drive one cycle of inputs, clock it, then compare outputs 1ns later.
    task automatic applyStimulus(input bit r, input bit pe, input logic [INST_W-1:0] inst,
                                 input logic [ADDR_W-1:0] pc, input bit dr, input bit clr,
                                 input string tag);
        rdy    = r;
        ifEn   = pe;
        ifInst = inst;
        ifPc   = pc;
        decRdy = dr;
        clear  = clr;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rdy = 1'b1; ifEn = 1'b0; ifInst = '0; ifPc = '0; decRdy = 1'b0; clear = 1'b0;
        rstN = 1'b1;
        #1 rstN = 1'b0;
        modelReset();
        #2 checkOutput("initReset");
        #9 rstN = 1'b1;

        // Warm up so outputs are non-zero, then reset mid-cycle.
        applyStimulus(1, 1, 32'hAAAA_0001, 32'h0000_0100, 0, 0, "warm0");
        applyStimulus(1, 1, 32'hAAAA_0002, 32'h0000_0104, 1, 0, "warm1");
        applyStimulus(1, 0, '0, '0, 1, 0, "warm2");
        #3 rstN = 1'b0;
        modelReset();
        #1 checkOutput("midReset");
        checkVal("midReset.enConst", 64'(decEn), 64'd0);
        #2 rstN = 1'b1;

        // Fill with 16 entries, decoder stalled.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1, 1, 32'h1000_0000 + 32'(k), 32'(4 * k), 0, 0, "fill");
            if (k == 12) checkVal("fill.fullAt13", 64'(fullOut), 64'd0);
            if (k == 13) checkVal("fill.fullAt14", 64'(fullOut), 64'd1);
        end
        applyStimulus(1, 1, 32'hBAD0_BAD0, 32'h0000_0040, 0, 0, "push17");
        checkVal("push17.flagged", 64'(dropped), 64'd1);

        // Drain: 16 consecutive pops in order, then idle.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1, 0, '0, '0, 1, 0, "drain");
            checkVal("drain.pcOrder", 64'(decPc), 64'(4 * k));
            checkVal("drain.enHigh", 64'(decEn), 64'd1);
        end
        applyStimulus(1, 0, '0, '0, 1, 0, "drainIdle");
        checkVal("drainIdle.enLow", 64'(decEn), 64'd0);

        // Simultaneous push and pop at full.
        for (int k = 0; k < 16; k++)
            applyStimulus(1, 1, 32'h2000_0000 + 32'(k), 32'h200 + 32'(4 * k), 0, 0, "refill");
        applyStimulus(1, 1, 32'hDEAD_BEEF, 32'h0000_BEEF, 1, 0, "pushPopFull");
        checkVal("pushPopFull.pc", 64'(decPc), 64'h200);
        for (int k = 0; k < 16; k++)
            applyStimulus(1, 0, '0, '0, 1, 0, "drainFull");
        checkVal("drainFull.lastInst", 64'(decInst), 64'hDEAD_BEEF);
        applyStimulus(1, 0, '0, '0, 1, 0, "drainFullIdle");

        // Wrap-around with steady push and pop.
        for (int k = 0; k < 40; k++)
            applyStimulus(1, 1, $urandom, 32'h1000 + 32'(4 * k), 1, 0, "wrap");
        applyStimulus(1, 0, '0, '0, 1, 0, "wrapTail");
        checkVal("wrapTail.pc", 64'(decPc), 64'h1000 + 64'(4 * 39));
        applyStimulus(1, 0, '0, '0, 1, 0, "wrapIdle");

        // Flush with a concurrent push and pop.
        for (int k = 0; k < 5; k++)
            applyStimulus(1, 1, $urandom, 32'h3000 + 32'(4 * k), 0, 0, "preFlush");
        applyStimulus(1, 1, 32'hFEED_F00D, 32'h0000_F00D, 1, 1, "flush");
        checkVal("flush.en", 64'(decEn), 64'd0);
        for (int k = 0; k < 3; k++)
            applyStimulus(1, 0, '0, '0, 1, 0, "postFlush");
        checkVal("postFlush.enLow", 64'(decEn), 64'd0);

        // rdy_in stall while pushing and popping.
        for (int k = 0; k < 4; k++)
            applyStimulus(1, 1, $urandom, 32'h4000 + 32'(4 * k), 0, 0, "preStall");
        applyStimulus(1, 0, '0, '0, 1, 0, "stallArm");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, $urandom, 32'h5000, 1, 0, "stall");
            checkVal("stall.enHeld", 64'(decEn), 64'd1);
            checkVal("stall.pcHeld", 64'(decPc), 64'h4000);
        end
        for (int k = 0; k < 4; k++)
            applyStimulus(1, 0, '0, '0, 1, 0, "resume");
        checkVal("resume.lastPc", 64'(decPc), 64'h400C);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(9, 0) != 0), ($urandom_range(9, 0) < 6), $urandom,
                          $urandom, ($urandom_range(1, 0) == 1), ($urandom_range(39, 0) == 0),
                          "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Circular FIFO between the fetch stage (IF) and the decoder.
- Buffers fetched instruction words and their PCs from IF, applies back-pressure to IF before overflow, and hands one entry per cycle to the decoder when the decoder is ready.
- The reorder buffer can flush the queue on a mispredict or exception.

Parameters:
DEPTH, 16, number of entries; power of two, ≥ 4
IDX_W, 4, pointer width = log2(DEPTH)
INST_W, 32, instruction word width (`IDWidth)
ADDR_W, 32, PC width (`AddressWidth)

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  reset; asynchronous, active-low
rdy_in  input  1  global ready; when low, all state and outputs hold
if_instqueue_en_in  input  1  push strobe from IF
if_instqueue_inst_in  input  INST_W  pushed instruction word
if_instqueue_pc_in  input  ADDR_W  pushed PC
instqueue_if_full_out  output  1  back-pressure to IF (almost-full)
decoder_instqueue_rdy_in  input  1  decoder can accept an entry this cycle
instqueue_decoder_en_out  output  1  one-cycle strobe: output entry valid
instqueue_decoder_inst_out  output  INST_W  popped instruction word
instqueue_decoder_pc_out  output  ADDR_W  popped PC
rob_instqueue_clear_in  input  1  flush all entries

Behaviour:
- State: storage arrays inst[DEPTH], pc[DEPTH]; head, tail (IDX_W, wrap modulo DEPTH); count (IDX_W+1, range 0..DEPTH).
- Reset (rst_in=0, asynchronous):
  - head=tail=count=0.
  - instqueue_decoder_en_out=0, inst_out=0, pc_out=0, instqueue_if_full_out=0.
  - Storage array contents are not reset.
- rdy_in=0:
  - No push, pop, or clear takes effect.
  - Every register and output holds its value, including en_out.
- Per rising edge with rdy_in=1, in priority order:
  1. Clear:
     - If rob_instqueue_clear_in=1: head=tail=count=0 and en_out=0.
     - A same-cycle push and a same-cycle pop are both discarded.
  2. Pop:
     - pop = decoder_instqueue_rdy_in && count≠0.
     - If pop: inst_out/pc_out ← entry[head], en_out ← 1, head ← head+1.
     - Otherwise en_out ← 0; inst_out/pc_out hold their last values.
  3. Push:
     - push = if_instqueue_en_in && (count<DEPTH || pop).
     - If push: entry[tail] ← {inst_in, pc_in}, tail ← tail+1.
     - A push into a completely full queue with no same-cycle pop is dropped, leaving state unchanged. This is a protocol violation and the bench flags it.
  4. Count update: count ← count + push − pop.
- Latency:
  - An entry pushed at edge N can be popped no earlier than edge N+1.
  - Its en_out pulse is therefore visible in cycle N+1..N+2.
  - There is no same-edge bypass from push to output.
- Back-pressure:
  - instqueue_if_full_out is registered: asserted when next count ≥ DEPTH−2, deasserted otherwise.
  - The two-entry margin absorbs IF's registered, in-flight push.
  - Clear forces full_out ← 0.
- Wrap-around: head and tail roll from DEPTH−1 to 0 with no gap and no lost entry.
- Ordering: strict FIFO.
- Back-to-back pops: en_out stays high on consecutive cycles while the decoder is ready and count≠0.

Test Plan:
- Reset and fill:
  - Stimulus: async reset mid-cycle, then push PCs 0x0,0x4,…,0x3C (16 pushes, decoder_rdy=0).
  - Response: all outputs 0 immediately on reset; full_out rises after the 14th push (count=14); count reaches 16; a 17th push is dropped and flagged.
- Drain order:
  - Stimulus: from full, decoder_rdy=1 for 16 cycles.
  - Response: en_out high 16 consecutive cycles; pc_out sequence 0x0…0x3C; en_out=0 afterwards; full_out drops once count<14.
- Simultaneous push/pop at full:
  - Stimulus: count=16, push inst 0xDEADBEEF with decoder_rdy=1.
  - Response: pop of head and push both accepted; count stays 16; 0xDEADBEEF emerges 16 pops later.
- Wrap-around:
  - Stimulus: steady push and pop, 40 entries with PCs 0x1000+4k.
  - Response: all 40 emerge in order; head and tail wrap twice; count never exceeds 2.
- Flush:
  - Stimulus: count=5, assert clear together with a push and decoder_rdy=1.
  - Response: next cycle count=0, en_out=0, full_out=0; the discarded push never appears at the output.
- rdy_in stall:
  - Stimulus: drop rdy_in for 3 cycles while pushing and popping.
  - Response: count, pointers, and en_out/inst_out/pc_out unchanged for those 3 cycles; normal operation resumes afterwards.
